jtdd_subshare: RTL

JTDD_SUBSHARE -- requirements
Module: jtdd_subshare

---
 rtl/jtdd_sub_pkg.sv | 22 ++
 rtl/jtdd_subshare_if.sv | 15 +
 rtl/jtframe_dual_ram.sv | 22 ++
 rtl/jtdd_subshare.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/jtdd_sub_pkg.sv
// Shared constants and halt-handshake state encoding for the main/sub CPU
// shared-RAM bridge.
package jtdd_sub_pkg;

    localparam int unsigned DEF_AW        = 10;
    localparam int unsigned DEF_NCH       = 2;
    localparam int unsigned DEF_RSTCNT    = 15;
    localparam int unsigned DEF_HALT_GATE = 1;

    typedef enum logic [1:0] {
        HALT_RUN  = 2'd0,
        HALT_REQ  = 2'd1,
        HALT_HALT = 2'd2,
        HALT_REL  = 2'd3
    } halt_st_e;

    // Bits needed to hold 0..n, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/jtdd_subshare_if.sv
// One port of the shared RAM: address, write data/strobe and registered
// read data.
interface jtdd_subshare_if #(
    parameter int unsigned AW = 10
) ();

    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    logic          we;
    logic [7:0]    rdata;

    modport master (output addr, wdata, we, input rdata);
    modport slave  (input addr, wdata, we, output rdata);

endinterface

// File: rtl/jtframe_dual_ram.sv
// True dual-port byte RAM, single clock, read-first on both ports.
// Port 0 is applied last, so it wins when both ports write one address.
module jtframe_dual_ram #(
    parameter int unsigned aw = 10
) (
    input  logic          clk,
    jtdd_subshare_if.slave p0,
    jtdd_subshare_if.slave p1
);

    localparam int unsigned DEPTH = 1 << aw;

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        p0.rdata <= mem[p0.addr];
        p1.rdata <= mem[p1.addr];
        if (p1.we) mem[p1.addr] <= p1.wdata;
        if (p0.we) mem[p0.addr] <= p0.wdata;
    end

endmodule

// File: rtl/jtdd_subshare.sv
// Main/sub CPU bridge: shared RAM, bus-halt handshake, sub reset stretch,
// NMI latch and sub-to-main doorbell interrupts.
module jtdd_subshare
    import jtdd_sub_pkg::*;
#(
    parameter int unsigned AW        = DEF_AW,
    parameter int unsigned NCH       = DEF_NCH,
    parameter int unsigned RSTCNT    = DEF_RSTCNT,
    parameter int unsigned HALT_GATE = DEF_HALT_GATE
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cen,
    input  logic           sub_rstb,
    // main CPU side
    input  logic [AW-1:0]  main_addr,
    input  logic [7:0]     main_dout,
    input  logic           main_wrn,
    input  logic           main_cs,
    output logic [7:0]     main_din,
    input  logic           main_halt,
    input  logic           main_nmi_set,
    output logic [NCH-1:0] main_irq,
    input  logic [NCH-1:0] main_irq_ack,
    output logic           main_collide,
    // sub CPU side
    input  logic [AW-1:0]  sub_addr,
    input  logic [7:0]     sub_dout,
    input  logic           sub_wrn,
    input  logic           sub_cs,
    output logic [7:0]     sub_din,
    input  logic           sub_nmi_ack,
    input  logic [NCH-1:0] sub_irq_set,
    input  logic           sub_busak_n,
    output logic           sub_busrq_n,
    output logic           sub_nmi_n,
    output logic           sub_rstn,
    output logic           halted
);

    localparam int unsigned          CW       = cnt_width(RSTCNT);
    localparam logic [CW-1:0]        RST_LOAD = CW'(RSTCNT);

    halt_st_e       st_q, st_d;
    logic           busrq_n_q, busrq_n_d;
    logic           halted_q, halted_d;
    logic [CW-1:0]  rcnt_q, rcnt_d;
    logic           sub_rstn_q, sub_rstn_d;
    logic           sub_wrn_hist_q, nmi_hist_q;
    logic           nmi_n_q, nmi_n_d;
    logic [NCH-1:0] irq_q, irq_d;
    logic           collide_q;

    logic           sub_we_c, main_we_raw_c, main_we_c, collide_c, nmi_set_c;

    // Reset stretch: held while any reset source is active, then counts cen ticks.
    always_comb begin
        rcnt_d     = rcnt_q;
        sub_rstn_d = sub_rstn_q;
        if (rst || !sub_rstb) begin
            rcnt_d     = RST_LOAD;
            sub_rstn_d = 1'b0;
        end else if (cen) begin
            if (rcnt_q != '0) rcnt_d = rcnt_q - CW'(1);
            else              sub_rstn_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        rcnt_q     <= rcnt_d;
        sub_rstn_q <= sub_rstn_d;
    end

    // Halt handshake next state; outputs are decoded from the next state so
    // they land in registers together with it.
    always_comb begin
        st_d      = st_q;
        busrq_n_d = 1'b1;
        halted_d  = 1'b0;
        case (st_q)
            HALT_RUN:  if (main_halt) st_d = HALT_REQ;
            HALT_REQ: begin
                if (!main_halt)       st_d = HALT_REL;
                else if (!sub_busak_n) st_d = HALT_HALT;
            end
            HALT_HALT: if (!main_halt)  st_d = HALT_REL;
            HALT_REL:  if (sub_busak_n) st_d = HALT_RUN;
            default:   st_d = HALT_RUN;
        endcase
        busrq_n_d = !((st_d == HALT_REQ) || (st_d == HALT_HALT));
        halted_d  = (st_d == HALT_HALT);
    end

    // Write strobes: sub writes once per falling wrn, main writes while allowed.
    always_comb begin
        sub_we_c      = sub_wrn_hist_q && !sub_wrn && sub_cs;
        main_we_raw_c = !main_wrn && main_cs && (halted_q || (HALT_GATE == 0));
        collide_c     = sub_we_c && main_we_raw_c && (sub_addr == main_addr);
        main_we_c     = main_we_raw_c && !collide_c;
    end

    // NMI latch and doorbells; both are wiped while the sub is held in reset.
    always_comb begin
        nmi_set_c = main_nmi_set && !nmi_hist_q;
        nmi_n_d   = nmi_n_q;
        irq_d     = irq_q;
        if (!sub_rstn_q) begin
            nmi_n_d = 1'b1;
            irq_d   = '0;
        end else begin
            if (nmi_set_c)        nmi_n_d = 1'b0;
            else if (sub_nmi_ack) nmi_n_d = 1'b1;
            irq_d = (irq_q & ~main_irq_ack) | sub_irq_set;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q           <= HALT_RUN;
            busrq_n_q      <= 1'b1;
            halted_q       <= 1'b0;
            sub_wrn_hist_q <= 1'b1;
            nmi_hist_q     <= 1'b0;
            nmi_n_q        <= 1'b1;
            irq_q          <= '0;
            collide_q      <= 1'b0;
        end else begin
            st_q           <= st_d;
            busrq_n_q      <= busrq_n_d;
            halted_q       <= halted_d;
            sub_wrn_hist_q <= sub_wrn;
            nmi_hist_q     <= main_nmi_set;
            nmi_n_q        <= nmi_n_d;
            irq_q          <= irq_d;
            collide_q      <= collide_c;
        end
    end

    jtdd_subshare_if #(.AW(AW)) sub_port  ();
    jtdd_subshare_if #(.AW(AW)) main_port ();

    assign sub_port.addr   = sub_addr;
    assign sub_port.wdata  = sub_dout;
    assign sub_port.we     = sub_we_c;
    assign main_port.addr  = main_addr;
    assign main_port.wdata = main_dout;
    assign main_port.we    = main_we_c;

    jtframe_dual_ram #(.aw(AW)) u_ram (
        .clk (clk),
        .p0  (sub_port),
        .p1  (main_port)
    );

    assign sub_din      = sub_port.rdata;
    assign main_din     = main_port.rdata;
    assign main_irq     = irq_q;
    assign main_collide = collide_q;
    assign sub_busrq_n  = busrq_n_q;
    assign sub_nmi_n    = nmi_n_q;
    assign sub_rstn     = sub_rstn_q;
    assign halted       = halted_q;

endmodule
